night_rider_monitor: RTL

Receive-side checker for the one-hot "night rider" LED bus. It samples a WIDTH-bit pattern produced by the LED sweep generator and locks onto the sweeping lit bit. It reports the lit position, sweep direction, step pulses and end-bounce count, and flags illegal patterns or a stalled sweep. It sits on the LED bus in loopback/self-test builds and in the verification harness for the generator.

---
 rtl/night_rider_pkg.sv | 26 ++
 rtl/night_rider_monitor_onehot_decode.sv | 26 ++
 rtl/night_rider_monitor.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/night_rider_pkg.sv
// Shared types and constants for the night-rider LED sweep generator and monitor.
package night_rider_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    FAULT   = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int TIMEOUT_1S = 20000000;

  // Classification of the registered pattern against the last accepted one.
  typedef struct packed {
    logic chg;     // pattern differs from last accepted
    logic onehot;  // exactly one LED lit
    logic adj;     // lit index is POS+1 or POS-1
    logic down;    // lit index is POS-1
    logic rev;     // step direction differs from DIR
    logic at_end;  // POS sits on bit 0 or bit WIDTH-1
  } step_t;

endpackage

// File: rtl/night_rider_monitor_onehot_decode.sv
// Combinational one-hot decoder: index of the set bit plus an exactly-one-set flag.
module onehot_decode #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]         vec,
  output logic [$clog2(WIDTH)-1:0] index,
  output logic                     is_onehot
);

  localparam int IW = $clog2(WIDTH);

  logic [WIDTH-1:0][IW-1:0] terms;

  // Each set bit contributes its own index; for a one-hot vector the OR is exact.
  for (genvar i = 0; i < WIDTH; i++) begin : g_term
    assign terms[i] = vec[i] ? IW'(i) : '0;
  end

  always_comb begin
    index = '0;
    for (int i = 0; i < WIDTH; i++) index = index | terms[i];
  end

  assign is_onehot = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/night_rider_monitor.sv
// Receive-side checker for the one-hot LED sweep: locks on, tracks position and
// direction, counts end bounces, and flags illegal patterns or a stalled sweep.
module night_rider_monitor
  import night_rider_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = TIMEOUT_1S,
  parameter int CNT_W   = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [WIDTH-1:0]         PATTERN,
  output logic [$clog2(WIDTH)-1:0] POS,
  output logic                     DIR,
  output logic                     VALID,
  output logic                     STEP,
  output logic [CNT_W-1:0]         BOUNCE_COUNT,
  output logic                     ERROR,
  output logic                     STALL
);

  localparam int IW = $clog2(WIDTH);
  localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW:0]   ONE_E     = (IW+1)'(1);
  localparam logic [IW-1:0] LAST      = IW'(WIDTH - 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT - 1);

  state_t             state, state_n;
  logic [WIDTH-1:0]   pat_q, pat_prev;
  logic [IW-1:0]      idx;
  logic               onehot;
  logic [IW-1:0]      pos_q;
  logic               dir_q, step_q, stall_q;
  logic [CNT_W-1:0]   bounce_q;
  logic [SW-1:0]      stall_cnt;
  step_t              st;
  logic               new_dir;
  logic               acq, legal, bounce_inc;

  onehot_decode #(.WIDTH(WIDTH)) u_dec (
    .vec       (pat_q),
    .index     (idx),
    .is_onehot (onehot)
  );

  // Input register and last-accepted pattern.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pat_q    <= '0;
      pat_prev <= '0;
    end else begin
      pat_q <= PATTERN;
      if (acq || legal) pat_prev <= pat_q;
    end
  end

  always_comb begin
    st.chg    = (pat_q != pat_prev);
    st.onehot = onehot;
    st.down   = ({1'b0, pos_q} == ({1'b0, idx} + ONE_E));
    st.adj    = st.down || ({1'b0, idx} == ({1'b0, pos_q} + ONE_E));
    new_dir   = st.down ? DIR_DOWN : DIR_UP;
    st.rev    = (new_dir != dir_q);
    st.at_end = (pos_q == '0) || (pos_q == LAST);
  end

  // FSM: state register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  // FSM: next state and per-cycle events.
  always_comb begin
    state_n    = state;
    acq        = 1'b0;
    legal      = 1'b0;
    bounce_inc = 1'b0;
    case (state)
      IDLE: begin
        if (st.onehot) begin
          state_n = ACQUIRE;
          acq     = 1'b1;
        end
      end
      ACQUIRE: begin
        // No direction is known yet, so either neighbour is a valid first step.
        if (st.chg) begin
          if (st.onehot && st.adj) begin
            state_n = TRACK;
            legal   = 1'b1;
          end else begin
            state_n = FAULT;
          end
        end
      end
      TRACK: begin
        if (st.chg) begin
          if (st.onehot && st.adj && (!st.rev || st.at_end)) begin
            legal      = 1'b1;
            bounce_inc = st.rev;
          end else begin
            state_n = FAULT;
          end
        end
      end
      FAULT: state_n = FAULT;
    endcase
  end

  // FSM: state-decoded outputs.
  always_comb begin
    VALID = (state == TRACK);
    ERROR = (state == FAULT);
  end

  // Position, direction and step pulse; frozen outside legal events.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pos_q  <= '0;
      dir_q  <= DIR_UP;
      step_q <= 1'b0;
    end else begin
      step_q <= legal;
      if (acq || legal) pos_q <= idx;
      if (legal)        dir_q <= new_dir;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)                                 bounce_q <= '0;
    else if (bounce_inc && bounce_q != '1)   bounce_q <= bounce_q + CNT_W'(1);
  end

  // Stall timer: only counts quiet TRACK cycles, holds once expired.
  always_ff @(posedge CLK) begin
    if (RST || legal || state_n != TRACK) begin
      stall_cnt <= '0;
      stall_q   <= 1'b0;
    end else if (stall_cnt == STALL_MAX) begin
      stall_q <= 1'b1;
    end else begin
      stall_cnt <= stall_cnt + SW'(1);
    end
  end

  assign POS          = pos_q;
  assign DIR          = dir_q;
  assign STEP         = step_q;
  assign BOUNCE_COUNT = bounce_q;
  assign STALL        = stall_q;

endmodule
